cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/step controller that sits between the board clock/buttons and the single-cycle RISC-V core.
- Generates the core reset sequence and a per-cycle clock enable (core_en).
- Modes: halt, free run, debounced single-step, or run exactly N cycles then stop with a done pulse.
- Counts executed cycles.
- Puts the "reset, clock N times, stop" bring-up sequence into synthesizable hardware for on-board debug.

Parameters:
CNT_W, 16, width of run_count and cycle counter
RST_CYCLES, 2, cycles core_rst is held after rst deasserts or after soft_rst (>=1)
DEB_CYCLES, 1000, consecutive stable samples required to accept a step_btn level change (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
soft_rst  in  1  synchronous request to re-run the core reset sequence
mode  in  2  00 halt, 01 free run, 10 single step, 11 run-N
start  in  1  one-cycle pulse; launches run-N when mode==11
step_btn  in  1  raw asynchronous push button
run_count  in  CNT_W  N for run-N, sampled on the start cycle
core_rst  out  1  reset to core, active high
core_en  out  1  registered clock enable to core
busy  out  1  high while in FREE, STEP or RUN_N
done  out  1  one-cycle pulse at run-N completion
cycles  out  CNT_W  count of core_en-high cycles, saturating

Behaviour:
- All outputs are registered.
- Reset (rst=1):
  - state=RST_SEQ, core_rst=1, core_en=0, busy=0, done=0, cycles=0.
  - Debouncer, synchronizer and counters are cleared.
  - rst has priority over every other input.
- RST_SEQ:
  - core_rst=1, core_en=0.
  - Holds for RST_CYCLES cycles after the last cycle with rst or soft_rst high, then enters IDLE with core_rst=0.
- soft_rst=1 in any state:
  - Enters RST_SEQ and clears cycles.
  - Aborts any run without a done pulse.
- IDLE: core_en=0, busy=0.
  - mode==01: go to FREE.
  - mode==10 and a debounced step edge: go to STEP.
  - mode==11 and start: load remaining=run_count.
    - If run_count==0: done=1 on the next cycle, stay IDLE, no enable.
    - Otherwise go to RUN_N.
  - mode==00: stay.
- FREE:
  - core_en=1 every cycle while mode==01.
  - Leaving mode 01: core_en=0 on the next cycle, state IDLE.
- STEP:
  - core_en=1 for exactly one cycle, then IDLE.
  - Exactly one enable per press. Further edges are ignored until the debounced level returns low and rises again.
- RUN_N:
  - start sampled at cycle t: core_en=1 on cycles t+1..t+N (exactly N cycles).
  - done=1 on cycle t+N+1 only; state IDLE.
  - start while in RUN_N is ignored.
  - mode change away from 11 during RUN_N: core_en=0 next cycle, IDLE, no done.
- step_btn path:
  - 2-flop synchronizer feeds a debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples that differ from the current level.
  - A rising edge of the debounced level is a step event.
  - Step events outside mode 10 or outside IDLE are discarded, not queued.
- cycles:
  - +1 on every cycle core_en=1.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by rst or soft_rst.
- Never both core_rst=1 and core_en=1.

Test Plan:
(Bench parameters: CNT_W=8, RST_CYCLES=2, DEB_CYCLES=4.)
1. rst high 3 cycles, then low; mode=00 → core_rst=1 through exactly 2 cycles after rst falls, then 0; core_en=0; cycles=0.
2. mode=11, run_count=5, start pulse at cycle t → core_en high t+1..t+5, done high only at t+6, cycles=5; a second start with run_count=0 → done at the next cycle, no core_en.
3. mode=10:
   - step_btn glitches 1-2 cycles wide → no core_en.
   - step_btn held 20 cycles → exactly one core_en pulse, cycles increments by 1.
   - Release and press again → a second pulse.
4. mode=01 for 300 cycles → core_en continuous; cycles saturates at 255.
5. RUN_N with run_count=10; after 4 enables switch mode to 00 → core_en drops the next cycle, no done, cycles=4.
6. soft_rst pulse mid free-run → core_en=0 and core_rst=1 the next cycle, held 2 cycles after soft_rst falls; cycles=0; then FREE resumes (mode still 01).

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the single-cycle core: reset sequencing, per-cycle
// clock enable generation (halt / free run / debounced step / run-N) and a
// saturating executed-cycle counter.
module cpu_run_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             step_btn,
  input  logic [CNT_W-1:0] run_count,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_RUNN = 2'b11;

  typedef enum logic [2:0] {
    S_RST_SEQ,
    S_IDLE,
    S_FREE,
    S_STEP,
    S_RUN_N
  } state_t;

  state_t           state, state_nx;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic             core_rst_nx, core_en_nx, busy_nx, done_nx;

  logic [1:0]       btn_sync;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             step_evt;

  // Synchronize the raw button, debounce it and flag debounced rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync  <= 2'b00;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      step_evt  <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      step_evt <= 1'b0;
      if (btn_sync[1] != deb_level) begin
        if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
          deb_level <= btn_sync[1];
          deb_cnt   <= '0;
          step_evt  <= btn_sync[1];
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST_SEQ;
      rst_cnt   <= RST_W'(RST_CYCLES);
      remaining <= '0;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      rst_cnt   <= rst_cnt_nx;
      remaining <= remaining_nx;
      core_rst  <= core_rst_nx;
      core_en   <= core_en_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Next state and next output values; an enable is issued in the same
  // cycle the state enters FREE, STEP or RUN_N.
  always_comb begin
    state_nx     = state;
    rst_cnt_nx   = rst_cnt;
    remaining_nx = remaining;
    core_rst_nx  = 1'b0;
    core_en_nx   = 1'b0;
    done_nx      = 1'b0;
    busy_nx      = 1'b0;

    if (soft_rst) begin
      state_nx    = S_RST_SEQ;
      rst_cnt_nx  = RST_W'(RST_CYCLES);
      core_rst_nx = 1'b1;
    end else begin
      case (state)
        S_RST_SEQ: begin
          if (rst_cnt <= RST_W'(1)) begin
            state_nx = S_IDLE;
          end else begin
            rst_cnt_nx  = rst_cnt - RST_W'(1);
            core_rst_nx = 1'b1;
          end
        end
        S_IDLE: begin
          case (mode)
            MODE_HALT: state_nx = S_IDLE;
            MODE_FREE: begin
              state_nx   = S_FREE;
              core_en_nx = 1'b1;
            end
            MODE_STEP: begin
              if (step_evt) begin
                state_nx   = S_STEP;
                core_en_nx = 1'b1;
              end
            end
            MODE_RUNN: begin
              if (start) begin
                if (run_count == '0) begin
                  remaining_nx = '0;
                  done_nx      = 1'b1;
                end else begin
                  remaining_nx = run_count - CNT_W'(1);
                  state_nx     = S_RUN_N;
                  core_en_nx   = 1'b1;
                end
              end
            end
            default: state_nx = S_IDLE;
          endcase
        end
        S_FREE: begin
          if (mode == MODE_FREE) begin
            core_en_nx = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_STEP: begin
          state_nx = S_IDLE;
        end
        S_RUN_N: begin
          if (mode != MODE_RUNN) begin
            state_nx = S_IDLE;
          end else if (remaining == '0) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            remaining_nx = remaining - CNT_W'(1);
            core_en_nx   = 1'b1;
          end
        end
        default: begin
          state_nx    = S_RST_SEQ;
          rst_cnt_nx  = RST_W'(RST_CYCLES);
          core_rst_nx = 1'b1;
        end
      endcase
    end

    busy_nx = (state_nx == S_FREE) || (state_nx == S_STEP) || (state_nx == S_RUN_N);
  end

  // Saturating count of enabled core cycles, tracking core_en as it is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (soft_rst) begin
      cycles <= '0;
    end else if (core_en_nx && (cycles != '1)) begin
      cycles <= cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with hand-computed expectations.
module tb_cpu_run_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             soft_rst;
  logic [1:0]       mode;
  logic             start;
  logic             step_btn;
  logic [CNT_W-1:0] run_count;
  logic             core_rst;
  logic             core_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_run_ctrl #(
    .CNT_W(CNT_W),
    .RST_CYCLES(2),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_rst(soft_rst),
    .mode(mode),
    .start(start),
    .step_btn(step_btn),
    .run_count(run_count),
    .core_rst(core_rst),
    .core_en(core_en),
    .busy(busy),
    .done(done),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int en_cnt;
  int done_cnt;
  int low_cnt;
  int both_cnt;

  // Count cycles where count of enables over n ticks, also tracking illegal rst+en.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      en_cnt   += int'(core_en);
      done_cnt += int'(done);
      low_cnt  += int'(!core_en);
      both_cnt += int'(core_en && core_rst);
    end
  endtask

  task automatic clear_counts();
    en_cnt = 0; done_cnt = 0; low_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; soft_rst = 1'b0; mode = 2'b00; start = 1'b0;
    step_btn = 1'b0; run_count = '0; both_cnt = 0;
    clear_counts();

    // 1. reset sequence
    tick(); tick(); tick();
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_hold1", 32'(core_rst), 32'd1);
    tick();
    check("rst_release", 32'(core_rst), 32'd0);
    clear_counts();
    run_ticks(5);
    check("halt_no_en", 32'(en_cnt), 32'd0);

    // 2. run-N with N=5, then N=0
    mode = 2'b11; run_count = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("runn_en_%0d", i), 32'(core_en), 32'd1);
      check($sformatf("runn_nodone_%0d", i), 32'(done), 32'd0);
      tick();
    end
    check("runn_en_end", 32'(core_en), 32'd0);
    check("runn_done", 32'(done), 32'd1);
    check("runn_cycles", 32'(cycles), 32'd5);
    tick();
    check("runn_done_once", 32'(done), 32'd0);
    run_count = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("run0_done", 32'(done), 32'd1);
    check("run0_en", 32'(core_en), 32'd0);
    check("run0_busy", 32'(busy), 32'd0);
    tick();
    check("run0_done_once", 32'(done), 32'd0);
    check("run0_cycles", 32'(cycles), 32'd5);

    // 3. single step: glitches, long press, second press
    mode = 2'b10;
    clear_counts();
    step_btn = 1'b1; tick(); step_btn = 1'b0;
    run_ticks(6);
    step_btn = 1'b1; tick(); tick(); step_btn = 1'b0;
    run_ticks(8);
    check("step_glitch_en", 32'(en_cnt), 32'd0);
    check("step_glitch_cycles", 32'(cycles), 32'd5);
    clear_counts();
    step_btn = 1'b1;
    run_ticks(20);
    check("step_press1_en", 32'(en_cnt), 32'd1);
    check("step_press1_cycles", 32'(cycles), 32'd6);
    step_btn = 1'b0;
    run_ticks(10);
    clear_counts();
    step_btn = 1'b1;
    run_ticks(20);
    step_btn = 1'b0;
    run_ticks(10);
    check("step_press2_en", 32'(en_cnt), 32'd1);
    check("step_press2_cycles", 32'(cycles), 32'd7);

    // 5. run-N aborted by mode change after 4 enables
    mode = 2'b11; run_count = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_en1", 32'(core_en), 32'd1);
    tick(); tick(); tick();
    check("abort_en4", 32'(core_en), 32'd1);
    mode = 2'b00;
    tick();
    check("abort_en_drop", 32'(core_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cycles", 32'(cycles), 32'd11);
    clear_counts();
    run_ticks(12);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_en", 32'(en_cnt), 32'd0);

    // 4. free run with saturation
    mode = 2'b01;
    clear_counts();
    run_ticks(100);
    check("free_mid_cycles", 32'(cycles), 32'd111);
    run_ticks(200);
    check("free_continuous", 32'(low_cnt), 32'd0);
    check("free_sat_cycles", 32'(cycles), 32'd255);
    check("free_busy", 32'(busy), 32'd1);

    // 6. soft reset mid free-run
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("soft_en", 32'(core_en), 32'd0);
    check("soft_core_rst", 32'(core_rst), 32'd1);
    check("soft_cycles", 32'(cycles), 32'd0);
    check("soft_busy", 32'(busy), 32'd0);
    tick();
    check("soft_hold", 32'(core_rst), 32'd1);
    tick();
    check("soft_release", 32'(core_rst), 32'd0);
    check("soft_release_en", 32'(core_en), 32'd0);
    tick();
    check("soft_resume_en", 32'(core_en), 32'd1);
    check("soft_resume_cycles", 32'(cycles), 32'd1);
    check("soft_resume_busy", 32'(busy), 32'd1);

    check("never_rst_and_en", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
